// File: rtl/ysyx_22040228_regfile_pkg.sv
// Shared constants for the ysyx_22040228 integer register file.
// XLEN, the register-address width, the zero word and the reset polarity are all defined here.
package ysyx_22040228_regfile_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int CW   = 64;

    localparam logic [XLEN-1:0] ZEROWORD = '0;
    localparam logic [AW-1:0]   ZEROREG  = '0;
    localparam logic            RST_ENA  = 1'b1;

endpackage

// File: rtl/ysyx_22040228_rf_rdport.sv
// Read mux for the register file. It returns zero when the port is disabled or addresses x0.
// Otherwise it forwards a same-cycle accepted write, and falls back to the array value.
module ysyx_22040228_rf_rdport
    import ysyx_22040228_regfile_pkg::*;
(
    input  logic            i_ena,
    input  logic [AW-1:0]   i_addr,
    input  logic [XLEN-1:0] i_reg_data,
    input  logic            i_wen,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0] o_data
);

    always_comb begin
        o_data = ZEROWORD;
        if (!i_ena || i_addr == ZEROREG) begin
            o_data = ZEROWORD;
        end else if (i_wen && i_wb_addr == i_addr) begin
            o_data = i_wb_data;
        end else begin
            o_data = i_reg_data;
        end
    end

endmodule

// File: rtl/ysyx_22040228_regfile.sv
// Integer register file: 32 x XLEN with x0 hardwired to zero and one write-back port.
// Two bypassing combinational read ports, a registered debug read port and a retired-write counter.
module ysyx_22040228_regfile
    import ysyx_22040228_regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_rd_ena,
    input  logic [AW-1:0]   wb_rd_addr,
    input  logic [XLEN-1:0] wb_rd_data,
    input  logic            rs1_ena,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic            rs2_ena,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [CW-1:0]   wr_count
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [XLEN-1:0] r_dbg_data;
    logic [CW-1:0]   r_wr_count;

    logic            w_rst;
    logic            w_wen;
    logic [XLEN-1:0] w_dbg_data;

    assign w_rst = (rst == RST_ENA);
    // Reset suppresses the write, so it also suppresses bypass on the read ports.
    assign w_wen = wb_rd_ena && (wb_rd_addr != ZEROREG) && !w_rst;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= ZEROWORD;
            end
            r_dbg_data <= ZEROWORD;
            r_wr_count <= '0;
        end else begin
            if (w_wen) begin
                r_regs[wb_rd_addr] <= wb_rd_data;
                r_wr_count         <= r_wr_count + 1'b1;
            end
            r_dbg_data <= w_dbg_data;
        end
    end

    ysyx_22040228_rf_rdport u_rs1 (
        .i_ena      (rs1_ena),
        .i_addr     (rs1_addr),
        .i_reg_data (r_regs[rs1_addr]),
        .i_wen      (w_wen),
        .i_wb_addr  (wb_rd_addr),
        .i_wb_data  (wb_rd_data),
        .o_data     (rs1_data)
    );

    ysyx_22040228_rf_rdport u_rs2 (
        .i_ena      (rs2_ena),
        .i_addr     (rs2_addr),
        .i_reg_data (r_regs[rs2_addr]),
        .i_wen      (w_wen),
        .i_wb_addr  (wb_rd_addr),
        .i_wb_data  (wb_rd_data),
        .o_data     (rs2_data)
    );

    // The debug port is always enabled and includes the bypass, so difftest sees the write it follows.
    ysyx_22040228_rf_rdport u_dbg (
        .i_ena      (1'b1),
        .i_addr     (dbg_addr),
        .i_reg_data (r_regs[dbg_addr]),
        .i_wen      (w_wen),
        .i_wb_addr  (wb_rd_addr),
        .i_wb_data  (wb_rd_data),
        .o_data     (w_dbg_data)
    );

    assign dbg_data = r_dbg_data;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_ysyx_22040228_regfile.sv
// Directed bench for ysyx_22040228_regfile with hand-computed expectations.
// Inputs change 1 ns after a rising edge and outputs are sampled 2 ns after it.
module tb_ysyx_22040228_regfile;
    import ysyx_22040228_regfile_pkg::*;

    logic            clk;
    logic            rst;
    logic            wb_rd_ena;
    logic [AW-1:0]   wb_rd_addr;
    logic [XLEN-1:0] wb_rd_data;
    logic            rs1_ena;
    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic            rs2_ena;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_data;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;
    logic [63:0]     wr_count;

    int checks;
    int errors;

    ysyx_22040228_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .wb_rd_ena  (wb_rd_ena),
        .wb_rd_addr (wb_rd_addr),
        .wb_rd_data (wb_rd_data),
        .rs1_ena    (rs1_ena),
        .rs1_addr   (rs1_addr),
        .rs1_data   (rs1_data),
        .rs2_ena    (rs2_ena),
        .rs2_addr   (rs2_addr),
        .rs2_data   (rs2_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .wr_count   (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic ena, input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
        wb_rd_ena  = ena;
        wb_rd_addr = addr;
        wb_rd_data = data;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set_wb(1'b0, 5'd0, 64'd0);
        rs1_ena = 1'b1; rs1_addr = 5'd0;
        rs2_ena = 1'b1; rs2_addr = 5'd0;
        dbg_addr = 5'd0;

        // Reset for two cycles, then every register reads zero.
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("rst_dbg", dbg_data, 64'd0);
        check_eq("rst_cnt", wr_count, 64'd0);
        for (int i = 1; i < NREG; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(i);
            #1;
            check_eq("rst_rs1", rs1_data, 64'd0);
            check_eq("rst_rs2", rs2_data, 64'd0);
        end

        // Write x5 with bypass on rs1, then read it from the array.
        step();
        set_wb(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001);
        rs1_addr = 5'd5;
        rs2_addr = 5'd6;
        #1;
        check_eq("byp_rs1", rs1_data, 64'hDEAD_BEEF_0000_0001);
        check_eq("byp_rs2_other", rs2_data, 64'd0);
        step();
        set_wb(1'b0, 5'd5, 64'd0);
        #1;
        check_eq("arr_rs1", rs1_data, 64'hDEAD_BEEF_0000_0001);
        check_eq("cnt_1", wr_count, 64'd1);

        // x0 writes are discarded and not counted.
        set_wb(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
        #1;
        check_eq("x0_rs1", rs1_data, 64'd0);
        check_eq("x0_rs2", rs2_data, 64'd0);
        step();
        set_wb(1'b0, 5'd0, 64'd0);
        #1;
        check_eq("x0_dbg", dbg_data, 64'd0);
        check_eq("x0_cnt", wr_count, 64'd1);

        // x7 = 0x99, then overwrite with 0x1234 while both ports read x7.
        set_wb(1'b1, 5'd7, 64'h99);
        dbg_addr = 5'd7;
        step();
        check_eq("dbg_99", dbg_data, 64'h99);
        set_wb(1'b1, 5'd7, 64'h1234);
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        #1;
        check_eq("dual_rs1", rs1_data, 64'h1234);
        check_eq("dual_rs2", rs2_data, 64'h1234);
        step();
        set_wb(1'b0, 5'd0, 64'd0);
        #1;
        check_eq("dbg_1234", dbg_data, 64'h1234);
        check_eq("cnt_3", wr_count, 64'd3);

        // Back-to-back writes to x10: the last one wins.
        set_wb(1'b1, 5'd10, 64'h1);
        step();
        set_wb(1'b1, 5'd10, 64'h2);
        step();
        set_wb(1'b0, 5'd0, 64'd0);
        rs1_addr = 5'd10;
        #1;
        check_eq("b2b_rs1", rs1_data, 64'h2);
        check_eq("b2b_cnt", wr_count, 64'd5);

        // A disabled read port returns zero regardless of contents.
        rs2_ena = 1'b0; rs2_addr = 5'd7;
        #1;
        check_eq("dis_rs2", rs2_data, 64'd0);
        rs2_ena = 1'b1;
        #1;
        check_eq("en_rs2", rs2_data, 64'h1234);

        // A write presented during reset is dropped and not bypassed.
        rst = 1'b1;
        set_wb(1'b1, 5'd3, 64'h55);
        rs1_addr = 5'd3;
        #1;
        check_eq("rst_nobyp", rs1_data, 64'd0);
        step();
        rst = 1'b0;
        set_wb(1'b0, 5'd0, 64'd0);
        #1;
        check_eq("rst_x3", rs1_data, 64'd0);
        check_eq("rst_x7", rs2_data, 64'd0);
        check_eq("rst_cnt2", wr_count, 64'd0);

        // First write is accepted in the cycle reset is released.
        set_wb(1'b1, 5'd4, 64'hA5);
        step();
        set_wb(1'b0, 5'd0, 64'd0);
        rs1_addr = 5'd4;
        #1;
        check_eq("post_rst_wr", rs1_data, 64'hA5);
        check_eq("post_rst_cnt", wr_count, 64'd1);

        // Counter wrap: preload all ones through the hierarchy, then one accepted write.
        force dut.r_wr_count = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_wr_count;
        #1;
        set_wb(1'b1, 5'd9, 64'hABC);
        step();
        set_wb(1'b0, 5'd0, 64'd0);
        rs1_addr = 5'd9;
        #1;
        check_eq("wrap_cnt", wr_count, 64'd0);
        check_eq("wrap_x9", rs1_data, 64'hABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22040228_regfile.md
# ysyx_22040228_regfile

Integer register file for the ysyx_22040228 RV64 core: the write-back sink of the memory-to-write-back pipeline register. It stores 32 general-purpose registers and accepts one write per cycle from the write-back stage. It serves two combinational read ports to decode with same-cycle write-through bypass, plus a registered debug read port and a retired-write counter for difftest.

## Interface
Parameters:
- XLEN, 64, register width
- NREG, 32, number of architectural registers
- AW, 5, register address width (log2 NREG)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wb_rd_ena  in  1  write-back write enable
- wb_rd_addr  in  AW  write-back destination register
- wb_rd_data  in  XLEN  write-back data
- rs1_ena  in  1  read port 1 enable
- rs1_addr  in  AW  read port 1 address
- rs1_data  out  XLEN  read port 1 data (combinational)
- rs2_ena  in  1  read port 2 enable
- rs2_addr  in  AW  read port 2 address
- rs2_data  out  XLEN  read port 2 data (combinational)
- dbg_addr  in  AW  debug/difftest read address
- dbg_data  out  XLEN  debug read data (registered)
- wr_count  out  64  count of architecturally effective writes

## Operation
- Storage: NREG x XLEN flops. x0 is hardwired zero.
- Write acceptance: `wen = wb_rd_ena && wb_rd_addr != 0 && !rst`. An accepted write updates `regs[wb_rd_addr]` at the rising edge. Writes to x0 are discarded and not counted.
- Read port n (n = 1, 2), evaluated in priority order:
  - `rsN_ena == 0` -> 0
  - `rsN_addr == 0` -> 0
  - `wen && wb_rd_addr == rsN_addr` -> `wb_rd_data` (bypass)
  - otherwise -> `regs[rsN_addr]`
- Both read ports resolve independently. Both may hit the bypass in the same cycle.
- Debug port: `dbg_data` is loaded every cycle with the port-1 rule applied to `dbg_addr`, with enable forced high, including the bypass.
- wr_count increments by 1 per accepted write and wraps from 2^64-1 to 0.
- The block has no stall input. The write-back register already gates `wb_rd_ena` to 0 during a flush or stall, so the register file obeys `wb_rd_ena` unconditionally.

## Timing
- Reset: in any cycle with rst=1, the next edge clears all registers, dbg_data and wr_count to 0. The write presented in that cycle is dropped.
  - rs1_data and rs2_data are combinational. During reset they still apply the rules above, but bypass is suppressed because wen=0.
- Read latency: 0 cycles (combinational). A write presented in cycle N is visible on rs1/rs2 in cycle N via bypass, and from the array from cycle N+1.
- Debug latency: 1 cycle. dbg_data in cycle N+1 reflects the value of dbg_addr in cycle N, including any write accepted in cycle N.
- Back-to-back writes to the same register: the last write wins. Each accepted write increments wr_count once.
- Reset is deasserted in cycle N: the first write can be accepted in cycle N.

## Structure
- Shared defines file (already included by the pipeline): XLEN, register-address bus width, the ZEROWORD constant, and reset-enable polarity. Do not introduce new local literals for these.
- Optional single sub-module `ysyx_22040228_rf_rdport`: one bypass-aware read mux, instantiated three times (rs1, rs2, dbg). The array and counter stay in the top module.
- Expected size: about 150 lines.

## Test plan
- Reset then read: assert rst for 2 cycles, release, then read x1..x31 on both ports -> all 0; dbg_data = 0; wr_count = 0.
- Write/read with bypass: write x5 = 0xDEAD_BEEF_0000_0001 with rs1_addr = 5 in the same cycle -> rs1_data = 0xDEAD_BEEF_0000_0001 that cycle; next cycle (wb_rd_ena = 0) it is still that value; wr_count = 1.
- x0 protection: write x0 = 0xFFFF_FFFF_FFFF_FFFF with rs1 = rs2 = dbg = 0 -> all outputs 0, wr_count unchanged.
- Dual-port conflict: rs1 = rs2 = 7 and write x7 = 0x1234 while x7 previously held 0x99 -> both ports read 0x1234 that cycle; dbg_addr = 7 gives dbg_data = 0x1234 the following cycle.
- Disabled read and reset mid-operation: rs2_ena = 0 gives rs2_data = 0 regardless of contents. Writing x3 = 0x55 with rst = 1 in the same cycle -> after release, x3 reads 0 and wr_count = 0.
- Counter wrap: force wr_count to 2^64-1 via a backdoor, then make one accepted write -> wr_count = 0.
